alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Shares the single 8-bit ALU (one registered result, combinational Z/C/N flags) between two requesters, e.g. the control sequencer (port 0) and the debug/monitor port (port 1). It uses round-robin arbitration with valid/ready handshakes on the request and response sides. It sequences each operation through issue, result capture and response, returning the result and its flags together as one atomic response.

Parameters:
DATA_W, 8, operand/result width; must match the ALU width.
OP_W, 2, ALU opcode width; values are the ALU_ADD/ALU_SUB/ALU_AND/ALU_OR encodings from microarch_defs.

Ports:
clk  input  1  clock; reset  input  1  synchronous, active-high
req_valid  input  2  per-requester request valid; bit i = requester i
req_ready  output  2  per-requester accept, one-hot or zero
req_a  input  2*DATA_W  operand A; [DATA_W-1:0] = requester 0, upper half = requester 1
req_b  input  2*DATA_W  operand B, same packing
req_op  input  2*OP_W  opcode, same packing
rsp_valid  output  2  response valid for the granted requester, one-hot or zero
rsp_ready  input  2  per-requester response accept
rsp_result  output  DATA_W  result of the completed operation
rsp_flags  output  3  {negative, carry, zero} of the completed operation
busy  output  1  high in any state other than IDLE
alu_a  output  DATA_W  to ALU a_in
alu_b  output  DATA_W  to ALU b_in
alu_op  output  OP_W  to ALU alu_op
alu_result  input  DATA_W  from ALU latched_result
alu_zero, alu_carry, alu_negative  input  1 each  combinational ALU flags

Behaviour:
- Reset (any state, including mid-operation): state=IDLE; req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, busy=0, alu_a=alu_b=0, alu_op=0; rr pointer last_grant=1, so requester 0 wins the first tie. Any in-flight operation is discarded and no response is issued.
- FSM states: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational. Bit g=1 iff state==IDLE and g is the arbitration winner among req_valid bits. If both are valid, the requester != last_grant wins.
  - On handshake (req_valid[g]&req_ready[g]): register the operands/opcode of g, set grant=g, go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (1 cycle): alu_a/alu_b/alu_op driven from the operand registers. At the closing edge, sample alu_zero/carry/negative into the flag regs; the ALU registers the result on the same edge.
- CAPT (1 cycle): operand registers still drive the ALU. At the closing edge, capture alu_result into rsp_result and load rsp_flags from the flag regs. Go to RESP.
- RESP:
  - rsp_valid[grant]=1; rsp_result and rsp_flags are held stable.
  - On rsp_ready[grant]: update last_grant=grant, clear rsp_valid, go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- The ALU input bus is 0 in IDLE and RESP, so idle ALU activity is deterministic.
- Latency: request accepted at edge T -> rsp_valid high from cycle T+3. Back-to-back throughput is one op per 4 cycles, with rsp_ready tied high.
- A new request cannot be accepted in the same cycle a response completes. IDLE is always entered for at least 1 cycle.
- Requester rules: operands must be held stable while req_valid is high and not yet accepted. Deasserting req_valid before acceptance withdraws the request with no side effects.
- Arithmetic: the arbiter performs no arithmetic. Flags reflect exactly the ALU semantics: carry = bit 8 of the 9-bit add/sub, SUB carry=1 means no borrow, carry=0 for AND/OR.
- Starvation freedom: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

Test Plan:
- Reset, then req0 ADD a=0x05 b=0x03 -> req_ready[0] same cycle; rsp_valid[0] 3 cycles later; rsp_result=0x08, flags {n,c,z}=000.
- req1 SUB 0x10-0x10 -> rsp_result=0x00, flags=011 (zero, no borrow). Then req1 SUB 0x01-0x02 -> rsp_result=0xFF, flags=100.
- req0 ADD 0xFF+0x01 -> rsp_result=0x00, flags=011. Then req0 AND 0xF0&0x0F -> 0x00, flags=001. Then OR 0x80|0x01 -> 0x81, flags=100.
- Both req_valid held high with distinct ops; grant order after reset is 0,1,0,1. rsp_valid is never set on both bits, and busy is high from T+1 until after each response handshake.
- Hold rsp_ready=0 for 5 cycles in RESP while req1 is valid -> rsp_result/flags stable, req_ready=0. req1 is granted only after rsp_ready[0] is asserted and IDLE is re-entered.
- Assert reset during CAPT -> next cycle all outputs are 0 and state is IDLE. No response is issued for the aborted op, and a subsequent req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one 8-bit ALU between two requesters.
// Each accepted op walks EXEC -> CAPT -> RESP and returns result+flags atomically.
module alu_arbiter #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [2*DATA_W-1:0]   req_a,
   input  logic [2*DATA_W-1:0]   req_b,
   input  logic [2*OP_W-1:0]     req_op,
   output logic [1:0]            rsp_valid,
   input  logic [1:0]            rsp_ready,
   output logic [DATA_W-1:0]     rsp_result,
   output logic [2:0]            rsp_flags,
   output logic                  busy,
   output logic [DATA_W-1:0]     alu_a,
   output logic [DATA_W-1:0]     alu_b,
   output logic [OP_W-1:0]       alu_op,
   input  logic [DATA_W-1:0]     alu_result,
   input  logic                  alu_zero,
   input  logic                  alu_carry,
   input  logic                  alu_negative
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_last_grant;
   logic                r_grant;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [OP_W-1:0]     r_op;
   logic [2:0]          r_flags;
   logic [DATA_W-1:0]   r_rsp_result;
   logic [2:0]          r_rsp_flags;

   logic                w_win;
   logic                w_accept;
   logic                w_rsp_done;
   logic                w_drive_alu;
   logic [DATA_W-1:0]   w_sel_a;
   logic [DATA_W-1:0]   w_sel_b;
   logic [OP_W-1:0]     w_sel_op;

   // On a tie the requester that was not served last wins.
   always_comb begin
      w_win = 1'b0;
      if (req_valid[0] && req_valid[1])
         w_win = ~r_last_grant;
      else if (req_valid[1])
         w_win = 1'b1;
   end

   assign w_accept   = (r_state == S_IDLE) && (|req_valid);
   assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_grant];

   always_comb begin
      req_ready = 2'b00;
      if (w_accept)
         req_ready[w_win] = 1'b1;
   end

   assign w_sel_a  = w_win ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
   assign w_sel_b  = w_win ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
   assign w_sel_op = w_win ? req_op[2*OP_W-1:OP_W]    : req_op[OP_W-1:0];

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)   w_state_next = S_EXEC;
         S_EXEC:  w_state_next = S_CAPT;
         S_CAPT:  w_state_next = S_RESP;
         S_RESP:  if (w_rsp_done) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
         r_flags      <= '0;
         r_rsp_result <= '0;
         r_rsp_flags  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_grant <= w_win;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
         end
         // Flags are combinational in the ALU, so they must be caught while EXEC drives it.
         if (r_state == S_EXEC)
            r_flags <= {alu_negative, alu_carry, alu_zero};
         if (r_state == S_CAPT) begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= r_flags;
         end
         if (w_rsp_done)
            r_last_grant <= r_grant;
      end
   end

   // The ALU bus is forced to zero outside EXEC/CAPT.
   assign w_drive_alu = (r_state == S_EXEC) || (r_state == S_CAPT);
   assign alu_a       = w_drive_alu ? r_a  : '0;
   assign alu_b       = w_drive_alu ? r_b  : '0;
   assign alu_op      = w_drive_alu ? r_op : '0;

   always_comb begin
      rsp_valid = 2'b00;
      if (r_state == S_RESP)
         rsp_valid[r_grant] = 1'b1;
   end

   assign rsp_result = r_rsp_result;
   assign rsp_flags  = r_rsp_flags;
   assign busy       = (r_state != S_IDLE);

endmodule
